// File: rtl/count_display_pkg.sv
// Shared definitions for count_display: conversion FSM encoding and 7-segment glyphs.
// Segment bit order is gfedcba with bit 0 = a, active high.
package count_display_pkg;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StConvert = 1'b1
  } state_e;

  localparam logic [6:0] Seg0     = 7'h3F;
  localparam logic [6:0] Seg1     = 7'h06;
  localparam logic [6:0] Seg2     = 7'h5B;
  localparam logic [6:0] Seg3     = 7'h4F;
  localparam logic [6:0] Seg4     = 7'h66;
  localparam logic [6:0] Seg5     = 7'h6D;
  localparam logic [6:0] Seg6     = 7'h7D;
  localparam logic [6:0] Seg7     = 7'h07;
  localparam logic [6:0] Seg8     = 7'h7F;
  localparam logic [6:0] Seg9     = 7'h6F;
  localparam logic [6:0] SegBlank = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-7-segment decoder; non-decimal nibbles render blank.
module seg7_decode
  import count_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SegBlank;
    case (digit_i)
      4'd0:    seg_o = Seg0;
      4'd1:    seg_o = Seg1;
      4'd2:    seg_o = Seg2;
      4'd3:    seg_o = Seg3;
      4'd4:    seg_o = Seg4;
      4'd5:    seg_o = Seg5;
      4'd6:    seg_o = Seg6;
      4'd7:    seg_o = Seg7;
      4'd8:    seg_o = Seg8;
      4'd9:    seg_o = Seg9;
      default: seg_o = SegBlank;
    endcase
  end

endmodule

// File: rtl/count_display.sv
// Binary-to-BCD converter (serial double dabble, one bit per cycle) feeding a
// continuously multiplexed 7-segment display driver.
module count_display
  import count_display_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N-1:0]        count,
  input  logic                load,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   digit_sel,
  output logic [6:0]          seg
);

  localparam int unsigned BcdW   = 4 * DIGITS;
  localparam int unsigned CntW   = $clog2(N + 1);
  localparam int unsigned PrescW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e            state_q, state_d;
  logic [N-1:0]      shift_q, shift_d;
  logic [BcdW-1:0]   scratch_q, scratch_d;
  logic [BcdW-1:0]   scratch_adj;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [CntW-1:0]   iter_q, iter_d;
  logic              done_q, done_d;

  logic [PrescW-1:0] presc_q, presc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        nibble;

  // Add-3 correction on every nibble that would overflow a decimal digit after the shift.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          shift_d   = count;
          scratch_d = '0;
          iter_d    = CntW'(N);
          state_d   = StConvert;
        end
      end
      StConvert: begin
        scratch_d = {scratch_adj[BcdW-2:0], shift_q[N-1]};
        shift_d   = shift_q << 1;
        iter_d    = iter_q - CntW'(1);
        if (iter_q == CntW'(1)) begin
          bcd_d   = scratch_d;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Display mux looks at the next digit index so seg and digit_sel move together.
  always_comb begin
    presc_d = presc_q + PrescW'(1);
    idx_d   = idx_q;
    if (presc_q == PrescW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
    nibble      = 4'd0;
    digit_sel_d = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_d == IdxW'(i)) begin
        nibble         = bcd_q[4*i +: 4];
        digit_sel_d[i] = 1'b1;
      end
    end
  end

  seg7_decode u_seg7_decode (
    .digit_i(nibble),
    .seg_o  (seg_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      scratch_q   <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
      done_q      <= 1'b0;
      presc_q     <= '0;
      idx_q       <= '0;
      digit_sel_q <= DIGITS'(1);
      seg_q       <= Seg0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      scratch_q   <= scratch_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
      done_q      <= done_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
    end
  end

  assign busy      = (state_q == StConvert);
  assign done      = done_q;
  assign bcd       = bcd_q;
  assign digit_sel = digit_sel_q;
  assign seg       = seg_q;

endmodule

// File: doc/count_display.md
COUNT_DISPLAY -- requirements
Module: count_display

Interface
REQ-001 Parameter N, default 4: width of the input count; the block SHALL support 1 <= N <= 16.
REQ-002 Parameter DIGITS, default 2: number of BCD digits; the block SHALL support configurations where 10^DIGITS > 2^N - 1.
REQ-003 Parameter REFRESH_DIV, default 4: clock cycles per displayed digit; the block SHALL support REFRESH_DIV >= 1.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 count  input  N  unsigned binary value from the upstream counter.
REQ-007 load  input  1  conversion request; SHALL be sampled on the rising edge.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  single-cycle pulse when a new bcd value is written.
REQ-010 bcd  output  4*DIGITS  last completed conversion; digit 0 (least significant) in bits [3:0].
REQ-011 digit_sel  output  DIGITS  one-hot active-high digit enable; bit i selects digit i.
REQ-012 seg  output  7  active-high segments, bit order gfedcba (bit 0 = a).

Function
REQ-013 Conversion FSM SHALL have exactly two states: IDLE and CONVERT.
REQ-014 In IDLE with load=1 at an edge, the block SHALL capture count into a shift register, clear the BCD scratch, set the iteration counter to N, and enter CONVERT (busy=1 after that edge).
REQ-015 In CONVERT, each edge SHALL perform one double-dabble iteration: add 3 to every scratch nibble >= 5, then shift the scratch left by one, inserting the shift-register MSB.
REQ-016 On the edge completing iteration N, the block SHALL write the final scratch into bcd, pulse done=1 for exactly one cycle, set busy=0, and return to IDLE.
REQ-017 Latency SHALL be exactly N cycles: load accepted at edge k yields done=1 and the new bcd after edge k+N.
REQ-018 load while busy=1 SHALL be ignored; changes on count during CONVERT SHALL NOT affect the result.
REQ-019 load in the cycle where done=1 SHALL be accepted, giving back-to-back conversions with no dead cycle.
REQ-020 bcd SHALL hold its value between conversions and SHALL NOT change during CONVERT.
REQ-021 The refresh prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on each wrap the digit index SHALL advance i -> (i+1) mod DIGITS.
REQ-022 digit_sel SHALL be one-hot of the digit index; seg SHALL be the registered decode of bcd nibble [index], so seg and digit_sel change on the same edge.
REQ-023 The decode SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex); nibbles 10-15 SHALL give 00 (blank).
REQ-024 The display path SHALL run continuously and independently of the FSM; a bcd update SHALL appear on seg from the next edge.

Reset
REQ-025 While reset=1: state=IDLE, busy=0, done=0, bcd=0, iteration counter=0, prescaler=0, digit index=0, digit_sel=one-hot bit 0, seg=3F.
REQ-026 Reset asserted during CONVERT SHALL abort the conversion with no done pulse, and bcd SHALL read 0.
REQ-027 After reset deasserts, the first load SHALL be accepted on the first rising edge.

Structure
REQ-028 A shared package count_display_pkg SHALL hold the state encoding (IDLE, CONVERT) and the segment constants for 0-9 and blank.
REQ-029 The segment decode SHALL be a separate combinational sub-module seg7_decode (4-bit in, 7-bit out); all other logic SHALL live in count_display.

Verification (N=4, DIGITS=2, REFRESH_DIV=4)
REQ-030 Reset, then idle 10 cycles -> bcd=00, busy=0, done never high, seg=3F in both digit slots, digit_sel toggles 01/10 every 4 cycles.
REQ-031 count=13, load for 1 cycle -> busy=1 for 4 cycles, done pulse after the 4th edge, bcd=8'h13.
REQ-032 count=15, load, then count=7 and load=1 during busy -> bcd=8'h15, exactly one done pulse.
REQ-033 After bcd=8'h13 -> seg=4F when digit_sel=01, seg=06 when digit_sel=10, each held 4 cycles.
REQ-034 count=12, load, reset pulse after 2 cycles of CONVERT -> no done, bcd=00; then count=9, load -> bcd=8'h09.
REQ-035 count=10, load asserted in the done cycle of a prior conversion -> accepted immediately, bcd=8'h10 exactly 4 cycles later.
